inject_ctrl: RTL
================

INJECT_CTRL -- requirements
Module: inject_ctrl

Interface
REQ-001: Parameter FLIT_W, default 64, flit width in bits.
REQ-002: Parameter DEPTH, default 4, injection queue entries (power of two).
REQ-003: Parameter STARVE_TH, default 8, wait cycles before starvation is flagged (1..15).
REQ-004: The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005: clk  input  1  rising-edge clock.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: pe_flit  input  FLIT_W  flit offered by local PE.
REQ-008: pe_valid  input  1  pe_flit is valid.
REQ-009: pe_ready  output  1  queue can accept a flit this cycle.
REQ-010: remain  input  `NUM_PORT  output ports still free after port allocation this cycle (bit 4 = local).
REQ-011: inj_flit  output  FLIT_W  flit injected into the crossbar.
REQ-012: inj_valid  output  1  injection occurs this cycle.
REQ-013: inj_port  output  `NUM_PORT  one-hot output port taken by the injected flit.
REQ-014: starve  output  1  injection starved; throttle request to neighbours.
REQ-015: occupancy  output  $clog2(DEPTH)+1  queued flit count.

Function
REQ-016: Queue SHALL be a FIFO of DEPTH entries; push on rising edge when pe_valid & pe_ready.
REQ-017: pe_ready SHALL equal (occupancy != DEPTH), independent of injection in the same cycle (no full-bypass).
REQ-018: Candidate ports SHALL be remain[3:0] only; the local port (bit 4) is never used for injection.
REQ-019: inj_valid SHALL be combinational: (occupancy != 0) & (|remain[3:0]).
REQ-020: inj_port SHALL be the one-hot highest set bit of remain[3:0] when inj_valid, else 0.
REQ-021: inj_flit SHALL be the FIFO head; value is don't-care when inj_valid = 0.
REQ-022: On the edge where inj_valid = 1 the head SHALL be popped.
REQ-023: Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024: A flit pushed into an empty queue SHALL NOT be injected before the following cycle (no empty-bypass; latency >= 1 cycle).
REQ-025: Read/write pointers SHALL wrap modulo DEPTH.
REQ-026: A 4-bit wait counter SHALL increment, saturating at 15, on each edge where occupancy != 0 and inj_valid = 0.
REQ-027: The wait counter SHALL clear on any edge with inj_valid = 1 or occupancy = 0.
REQ-028: FSM states are IDLE, WAIT and STARVE.
REQ-029: IDLE: occupancy = 0; go to WAIT on the edge where occupancy becomes nonzero.
REQ-030: WAIT: go to STARVE when the wait counter reaches STARVE_TH; go to IDLE when the queue empties.
REQ-031: STARVE: go to WAIT on injection with occupancy remaining > 0; go to IDLE on injection leaving the queue empty.
REQ-032: starve SHALL be a registered output, 1 iff state = STARVE.
REQ-033: remain = 0 with a non-empty queue SHALL inject nothing and count a wait cycle.
REQ-034: remain containing only bit 4 SHALL be treated as no free port.

Reset
REQ-035: While reset = 1, without waiting for a clock edge: pointers = 0, occupancy = 0, wait counter = 0, state = IDLE, starve = 0.
REQ-036: While reset = 1, without waiting for a clock edge: pe_ready = 1, inj_valid = 0, inj_port = 0.
REQ-037: Reset asserted mid-operation SHALL discard all queued flits; the first push after reset release is the next head.

Verification
REQ-038: Push A,B,C on consecutive cycles with remain = 5'b00000 -> occupancy 3, inj_valid 0; then remain = 5'b00110 -> inj_valid = 1, inj_port = 5'b00100, inj_flit = A, then B, then C in order.
REQ-039: Push 4 flits with remain = 0 -> pe_ready = 0; pe_valid held high during a pop cycle -> no push that cycle; pe_ready = 1 next cycle, occupancy 3.
REQ-040: Queue non-empty, remain = 5'b10000 for 8 cycles (STARVE_TH = 8) -> starve = 1 after the 8th edge, counter saturates at 15; remain = 5'b00001 -> inj_port = 5'b00001, starve = 0 on the next edge.
REQ-041: Push into empty queue with remain = 5'b01111 the same cycle -> inj_valid = 0 that cycle, inj_valid = 1 with inj_port = 5'b01000 next cycle.
REQ-042: Simultaneous push and pop at occupancy 2 for 10 cycles with pointer wrap -> occupancy stays 2, output order equals input order.
REQ-043: Reset pulse between clock edges with occupancy 3 and state STARVE -> occupancy 0, starve 0, pe_ready 1 immediately, before the next edge.

Source files
------------

// File: rtl/inject_ctrl.sv
// Local injection controller: a DEPTH-entry flit FIFO that injects its head into
// the highest free crossbar port left over by allocation, and flags starvation.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module inject_ctrl #(
   parameter int FLIT_W    = 64,
   parameter int DEPTH     = 4,
   parameter int STARVE_TH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [FLIT_W-1:0]         pe_flit,
   input  logic                      pe_valid,
   output logic                      pe_ready,
   input  logic [`NUM_PORT-1:0]      remain,
   output logic [FLIT_W-1:0]         inj_flit,
   output logic                      inj_valid,
   output logic [`NUM_PORT-1:0]      inj_port,
   output logic                      starve,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FULL = OW'(DEPTH);
   localparam logic [3:0]    TH   = 4'(STARVE_TH);

   typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [OW-1:0]     occ_next;
   logic [3:0]        wait_cnt, cnt_next;
   state_t            state;
   logic              push, pop;

   // The local port never carries an injected flit, so bit 4 is ignored.
   logic unused_local;
   assign unused_local = remain[4];

   assign pe_ready  = (occupancy != FULL);
   assign inj_valid = (occupancy != '0) & (|remain[3:0]);
   assign inj_flit  = mem[rd_ptr];
   assign push      = pe_valid & pe_ready;
   assign pop       = inj_valid;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      inj_port = '0;
      if (inj_valid) begin
         if (remain[3])      inj_port[3] = 1'b1;
         else if (remain[2]) inj_port[2] = 1'b1;
         else if (remain[1]) inj_port[1] = 1'b1;
         else                inj_port[0] = 1'b1;
      end
   end

   always_comb begin
      occ_next = occupancy;
      if (push && !pop)      occ_next = occupancy + 1'b1;
      else if (pop && !push) occ_next = occupancy - 1'b1;

      cnt_next = wait_cnt;
      if (inj_valid || occupancy == '0) cnt_next = '0;
      else if (wait_cnt != 4'hf)        cnt_next = wait_cnt + 1'b1;
   end

   // NOTE: flit storage has no reset; only pointers and occupancy decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pe_flit;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         wait_cnt  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occ_next;
         wait_cnt  <= cnt_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         starve <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (occ_next != '0) state <= WAIT;
               starve <= 1'b0;
            end
            WAIT: begin
               if (occ_next == '0) begin
                  state  <= IDLE;
                  starve <= 1'b0;
               end else if (cnt_next == TH) begin
                  state  <= STARVE;
                  starve <= 1'b1;
               end else begin
                  starve <= 1'b0;
               end
            end
            STARVE: begin
               if (pop) begin
                  state  <= (occ_next != '0) ? WAIT : IDLE;
                  starve <= 1'b0;
               end else begin
                  starve <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               starve <= 1'b0;
            end
         endcase
      end
   end

endmodule
